// File: rtl/proc_pkg.sv
// Shared types and defaults for the multicore register bank: FSM state set,
// default geometry and flattened-bus slice indexing.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    BC_CAP = 2'd2,
    BC_WR  = 2'd3
  } state_t;

  localparam int unsigned DEF_REG_WIDTH  = 12;
  localparam int unsigned DEF_REG_COUNT  = 16;
  localparam int unsigned DEF_CORE_COUNT = 11;

  // Low bit of element idx in a flattened bus of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/core_reg_file.sv
// One core's register file: two combinational reads, a core/init write port,
// a broadcast write port, and a peek read used to capture the broadcast source.
module core_reg_file
  import proc_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned REG_COUNT  = DEF_REG_COUNT,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [REG_WIDTH-1:0]  i_wr_data,
  input  logic                  i_bc_en,
  input  logic [ADDR_WIDTH-1:0] i_bc_addr,
  input  logic [REG_WIDTH-1:0]  i_bc_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
  output logic [REG_WIDTH-1:0]  o_rd_data_a,
  output logic [REG_WIDTH-1:0]  o_rd_data_b,
  output logic [REG_WIDTH-1:0]  o_peek_data
);

  logic [REG_WIDTH-1:0] r_mem [REG_COUNT];

  // A broadcast and a core write may land in the same cycle; the broadcast is
  // assigned last so it wins when both target the same address.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_wr_en && (i_wr_addr != '0)) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_bc_en && (i_bc_addr != '0)) begin
        r_mem[i_bc_addr] <= i_bc_data;
      end
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
  assign o_peek_data = (i_bc_addr   == '0) ? '0 : r_mem[i_bc_addr];

endmodule

// File: rtl/multicore_reg_bank.sv
// Per-core register files with a start-triggered core-ID init sequence and a
// two-step broadcast that copies one core's register into every core.
module multicore_reg_bank
  import proc_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
  parameter int unsigned REG_COUNT   = DEF_REG_COUNT,
  parameter int unsigned CORE_COUNT  = DEF_CORE_COUNT,
  parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int unsigned CORE_ID_REG = REG_COUNT - 1,
  parameter int unsigned CID_WIDTH   = $clog2(CORE_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CORE_COUNT-1:0]            wr_en,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] wr_addr,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]  wr_data,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] rd_addr_b,
  output logic [CORE_COUNT*REG_WIDTH-1:0]  rd_data_a,
  output logic [CORE_COUNT*REG_WIDTH-1:0]  rd_data_b,
  input  logic                             bc_req,
  input  logic [CID_WIDTH-1:0]             bc_src,
  input  logic [ADDR_WIDTH-1:0]            bc_addr,
  output logic                             bc_ack,
  output logic                             busy,
  output logic                             done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [REG_WIDTH-1:0]  r_bc_val;
  logic [REG_WIDTH-1:0]  w_bc_pick;
  logic [REG_WIDTH-1:0]  w_peek [CORE_COUNT];
  logic                  w_cnt_last;
  logic                  w_cnt_id;
  logic                  w_bc_valid;
  logic                  w_in_init;
  logic                  w_in_bc_wr;

  assign w_cnt_last = (r_cnt == ADDR_WIDTH'(REG_COUNT - 1));
  assign w_cnt_id   = (r_cnt == ADDR_WIDTH'(CORE_ID_REG));
  assign w_bc_valid = (32'(bc_src) < CORE_COUNT);
  assign w_in_init  = (r_state == INIT);
  assign w_in_bc_wr = (r_state == BC_WR);

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    bc_ack      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = INIT;
        end else if (bc_req && w_bc_valid) begin
          w_state_nxt = BC_CAP;
        end
      end
      INIT: begin
        if (w_cnt_last) begin
          done        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      BC_CAP: w_state_nxt = BC_WR;
      BC_WR: begin
        bc_ack      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bc_val <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_init && !w_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == BC_CAP) begin
        r_bc_val <= w_bc_pick;
      end
    end
  end

  // bc_src is held stable through the request, so this mux reads the source
  // core's register as it stands before the capture edge.
  always_comb begin
    w_bc_pick = '0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      if (bc_src == CID_WIDTH'(k)) begin
        w_bc_pick = w_peek[k];
      end
    end
  end

  for (genvar k = 0; k < CORE_COUNT; k++) begin : g_core
    localparam logic [REG_WIDTH-1:0] LP_CID = REG_WIDTH'(k);

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [REG_WIDTH-1:0]  w_wdata;

    always_comb begin
      w_we    = wr_en[k];
      w_waddr = wr_addr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      w_wdata = wr_data[slice_lo(k, REG_WIDTH) +: REG_WIDTH];
      if (w_in_init) begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = w_cnt_id ? LP_CID : '0;
      end
    end

    core_reg_file #(
      .REG_WIDTH (REG_WIDTH),
      .REG_COUNT (REG_COUNT),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rf (
      .clk        (clk),
      .i_reset    (reset),
      .i_wr_en    (w_we),
      .i_wr_addr  (w_waddr),
      .i_wr_data  (w_wdata),
      .i_bc_en    (w_in_bc_wr),
      .i_bc_addr  (bc_addr),
      .i_bc_data  (r_bc_val),
      .i_rd_addr_a(rd_addr_a[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]),
      .i_rd_addr_b(rd_addr_b[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]),
      .o_rd_data_a(rd_data_a[slice_lo(k, REG_WIDTH) +: REG_WIDTH]),
      .o_rd_data_b(rd_data_b[slice_lo(k, REG_WIDTH) +: REG_WIDTH]),
      .o_peek_data(w_peek[k])
    );
  end

endmodule

// File: doc/multicore_reg_bank.md
Name: multicore_reg_bank

Overview:
- Parametrised per-core register storage for the multiport processor: one register file per core, 2 combinational read ports and 1 write port per core.
- Adds a start-triggered init sequence that loads each core's ID into a fixed register.
- Adds a broadcast mode that copies one core's register into the same address of every core.
- Sits between the core datapaths and the top-level start/clk/reset control.

Parameters:
- REG_WIDTH, 12, register data width.
- REG_COUNT, 16, registers per core (power of 2, >=4).
- CORE_COUNT, 11, number of cores/register files.
- ADDR_WIDTH, $clog2(REG_COUNT) = 4, register address width.
- CORE_ID_REG, REG_COUNT-1, register loaded with core index during init.
- CID_WIDTH, $clog2(CORE_COUNT) = 4, core-index width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  launches the init sequence; sampled only in IDLE.
- wr_en  in  CORE_COUNT  per-core write enable.
- wr_addr  in  CORE_COUNT*ADDR_WIDTH  per-core write address; core k at slice k.
- wr_data  in  CORE_COUNT*REG_WIDTH  per-core write data.
- rd_addr_a  in  CORE_COUNT*ADDR_WIDTH  per-core read address A.
- rd_addr_b  in  CORE_COUNT*ADDR_WIDTH  per-core read address B.
- rd_data_a  out  CORE_COUNT*REG_WIDTH  per-core read data A.
- rd_data_b  out  CORE_COUNT*REG_WIDTH  per-core read data B.
- bc_req  in  1  broadcast request; level, held until bc_ack.
- bc_src  in  CID_WIDTH  source core index.
- bc_addr  in  ADDR_WIDTH  broadcast register address.
- bc_ack  out  1  one-cycle pulse when the broadcast write commits.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse on the last init cycle.

Behaviour:
- Reset:
  - All registers are cleared to 0.
  - FSM goes to IDLE and the init counter to 0.
  - busy, done and bc_ack are 0.
  - Reset mid-INIT or mid-broadcast aborts the operation; no partial writes after the reset edge.
- Register 0: reads always return 0; writes to it are ignored, including init and broadcast writes.
- Reads:
  - Combinational from the current register contents; no write bypass.
  - A write becomes visible the cycle after its edge.
  - Two ports of the same core reading the same address both return the same value.
- Core writes: in IDLE, BC_CAP and BC_WR, each core with wr_en=1 writes its own file at the next edge; cores are independent.
- FSM states: IDLE, INIT, BC_CAP, BC_WR.
- IDLE:
  - start=1 -> INIT with cnt=0. start takes priority over bc_req; the bc_req stays pending.
  - Else bc_req=1 and bc_src<CORE_COUNT -> BC_CAP.
  - bc_req with bc_src>=CORE_COUNT is ignored: no ack, stay in IDLE.
- INIT:
  - Each cycle, address cnt is written in all cores: core k gets k (zero-extended) if cnt==CORE_ID_REG, else 0.
  - cnt increments; all core writes are blocked.
  - start is ignored.
  - Lasts REG_COUNT cycles. done=1 in the cycle cnt==REG_COUNT-1, then IDLE.
- BC_CAP: latch file[bc_src][bc_addr] (pre-edge value) into bc_val; -> BC_WR.
- BC_WR:
  - Write bc_val to bc_addr in every core; bc_ack=1; -> IDLE.
  - A core write in this cycle to bc_addr is overridden by the broadcast; core writes to other addresses proceed.
  - bc_src/bc_addr must be held stable from request through ack.
- Next request: if bc_req is still high after ack, a new broadcast starts; minimum 3 cycles per broadcast (IDLE, BC_CAP, BC_WR).
- Widths:
  - Core k slice is bits [(k+1)*W-1 : k*W].
  - Core index is zero-extended or truncated to REG_WIDTH.

Decomposition:
- Shared package proc_pkg:
  - FSM state enum (IDLE/INIT/BC_CAP/BC_WR).
  - Default widths REG_WIDTH, REG_COUNT, CORE_COUNT.
  - Helper for slice indexing.
- Sub-module core_reg_file: one core's REG_COUNT x REG_WIDTH array.
  - 2 combinational reads, 1 write port, register-0 masking.
  - Instantiated CORE_COUNT times via generate.
  - Write mux (core / init / broadcast) lives in the top.

Test Plan:
- Reset, then start pulse:
  - busy=1 for 16 cycles; done pulses on the 16th.
  - Afterwards core 7 reg15 reads 7, core 10 reg15 reads 10, core 3 reg5 reads 0.
- Core 2 writes reg3=0xABC while core 4 writes reg3=0x123 in the same cycle:
  - Next cycle core2 rd_a(3)=0xABC, core4 rd_b(3)=0x123.
  - Write to reg0 of 0xFFF reads back 0.
- bc_req with src=2, addr=3:
  - bc_ack 2 cycles after acceptance.
  - All 11 cores read reg3=0xABC afterwards.
  - Core 5 writing reg3=0x555 in the BC_WR cycle is overridden -> 0xABC; core 5 writing reg4=0x555 in that cycle sticks.
- start and bc_req asserted together in IDLE:
  - INIT runs first (16 cycles, writes blocked).
  - Then the broadcast completes with bc_ack.
  - bc_src=12: no ack, busy stays 0.
- reset asserted at init cycle 5:
  - Next cycle busy=0, done never pulses.
  - All registers read 0, including core 7 reg15.
